data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, the number of 32-bit words in the data array (power of 2).
REQ-002 The block SHALL have parameter SB_DEPTH, default 4, the number of store-buffer entries (power of 2).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, ports named CLK and RESET.
REQ-004 Ports SHALL be:
CLK  in  1  clock, all state on rising edge
RESET  in  1  synchronous, active-high reset
data_address_2DM  in  32  byte address; reads use the word index, writes use the byte offset
data_write_2DM  in  32  store data, right-justified (low n bytes valid)
data_write_size_2DM  in  2  0=4 bytes, 1=1 byte, 2=2 bytes, 3=3 bytes
MemRead_2DM  in  1  load request this cycle
MemWrite_2DM  in  1  store request this cycle
data_read_fDM  out  32  load data, combinational, same cycle
MEM_Stall  out  1  request not serviced this cycle; initiator holds it
Misaligned_Err  out  1  one-cycle registered pulse; a store was rejected
SB_Empty  out  1  store buffer holds no entries

Function
REQ-005 Byte order SHALL be big-endian: byte offset 0 maps to bits [31:24] and offset 3 maps to bits [7:0].
REQ-006 The word index SHALL be data_address_2DM[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored (the array wraps).
REQ-007 A store of n bytes at offset o SHALL write data_write_2DM[8n-1:0] to bytes o..o+n-1, most significant byte first.
REQ-008 A store with o+n>4 SHALL be rejected: no entry is taken, MEM_Stall stays low, and Misaligned_Err is 1 on the next cycle.
REQ-009 An accepted store SHALL enter the store buffer as {word index, 32-bit lane-aligned data, 4-bit byte enable} in the same cycle.
REQ-010 A load SHALL return, in the same cycle, the array word merged per byte with all matching buffer entries, youngest entry winning.
REQ-011 When both MemRead_2DM and MemWrite_2DM are high, data_read_fDM SHALL reflect state before that cycle's store, and the store SHALL be accepted.
REQ-012 Drain SHALL write the head entry into the array using its byte enables only, one entry per cycle.
REQ-013 Drain SHALL occur when the buffer is non-empty and either MemRead_2DM is low or the buffer is full, because the array is single-ported.
REQ-014 When count==SB_DEPTH and MemRead_2DM or MemWrite_2DM is high, MEM_Stall SHALL be 1, the request SHALL be ignored, data_read_fDM SHALL be 0, and a forced drain SHALL occur.
REQ-015 A same-cycle accept and drain SHALL leave count unchanged; pointers SHALL wrap modulo SB_DEPTH.
REQ-016 SB_Empty SHALL equal (count==0), combinational from registered state.
REQ-017 With neither request high, data_read_fDM SHALL be 0.

Reset
REQ-018 RESET SHALL clear count, head and tail pointers, and Misaligned_Err to 0; SB_Empty SHALL therefore be 1.
REQ-019 RESET SHALL NOT clear the data array; buffered stores pending at reset SHALL be discarded.
REQ-020 During RESET, requests SHALL be ignored and MEM_Stall SHALL be 0.

Structure
REQ-021 Package mem_pkg SHALL hold the size-encoding constants, the byte-lane/byte-enable function (size, offset -> 4-bit enable) and the store-entry struct.
REQ-022 The store FIFO with per-byte youngest-match forwarding SHALL be the sub-module store_buffer; the array and drain arbitration SHALL live in the top level.

Verification
REQ-023 SW 0x11223344 @0x100, then LW @0x100 next cycle -> data_read_fDM=0x11223344 via forwarding, with SB_Empty=0.
REQ-024 SB 0x..AA @0x101 over array word 0x11223344, idle 2 cycles, LW @0x100 -> 0x11AA3344 and SB_Empty=1.
REQ-025 Size 3 with data 0x00CCDDEE @0x202 -> rejected; Misaligned_Err=1 for exactly one cycle; array and buffer unchanged.
REQ-026 Four SWs to distinct words while MemRead_2DM is held high, then a fifth -> MEM_Stall=1 that cycle; the fifth is accepted the next cycle; all five read back correctly.
REQ-027 SH 0xBEEF @0x302 then SB 0x77 @0x303 back-to-back, LW @0x300 (array word 0) -> 0x0000BE77.
REQ-028 Two SWs buffered, RESET for one cycle, then LW of those addresses -> old array contents and SB_Empty=1.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - size encodings, byte-lane helpers and store-buffer entry type
package mem_pkg;

  localparam logic [1:0] SZ_WORD   = 2'd0;
  localparam logic [1:0] SZ_BYTE   = 2'd1;
  localparam logic [1:0] SZ_HALF   = 2'd2;
  localparam logic [1:0] SZ_TRIPLE = 2'd3;

  typedef struct packed {
    logic [29:0] idx;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    return (size == SZ_WORD) ? 3'd4 : {1'b0, size};
  endfunction

  // Big-endian lanes: offset 0 is be[3] / bits [31:24].
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    int o;
    int n;
    logic [3:0] be;
    o  = int'(off);
    n  = int'(size_bytes(size));
    be = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      if (b >= o && b < o + n) be[3-b] = 1'b1;
    end
    return be;
  endfunction

  function automatic logic [31:0] lane_data(input logic [31:0] data, input logic [1:0] size,
                                            input logic [1:0] off);
    int o;
    int n;
    logic [31:0] res;
    o   = int'(off);
    n   = int'(size_bytes(size));
    res = '0;
    for (int b = 0; b < 4; b++) begin
      if (b >= o && b < o + n) res[8*(3-b) +: 8] = data[8*(n-1-(b-o)) +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO with per-byte youngest-match load forwarding
module store_buffer
  import mem_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      push,
  input  sb_entry_t                 push_entry,
  input  logic                      pop,
  output sb_entry_t                 head_entry,
  output logic [$clog2(SB_DEPTH):0] count,
  input  logic [29:0]               lookup_idx,
  input  logic [31:0]               lookup_base,
  output logic [31:0]               lookup_data
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t       entries [SB_DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   slot;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) entries[tail] <= push_entry;
  end

  assign head_entry = entries[head];

  // Walk oldest to youngest so later matches overwrite earlier ones per byte.
  always_comb begin
    lookup_data = lookup_base;
    slot        = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      slot = head + PW'(i);
      if (CW'(i) < count && entries[slot].idx == lookup_idx) begin
        for (int b = 0; b < 4; b++) begin
          if (entries[slot].be[b]) lookup_data[8*b +: 8] = entries[slot].data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-ported data array fronted by a forwarding store buffer
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int SB_DEPTH    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] data_address_2DM,
  input  logic [31:0] data_write_2DM,
  input  logic [1:0]  data_write_size_2DM,
  input  logic        MemRead_2DM,
  input  logic        MemWrite_2DM,
  output logic [31:0] data_read_fDM,
  output logic        MEM_Stall,
  output logic        Misaligned_Err,
  output logic        SB_Empty
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(SB_DEPTH) + 1;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [1:0]    offset;
  logic [CW-1:0] sb_count;
  logic          sb_full;
  logic          misaligned;
  logic          accept;
  logic          drain;
  logic [31:0]   fwd_data;
  sb_entry_t     push_entry;
  sb_entry_t     head_entry;
  logic          unused_bits;

  assign word_idx   = data_address_2DM[AW+1:2];
  assign offset     = data_address_2DM[1:0];
  assign sb_full    = (sb_count == CW'(SB_DEPTH));
  assign SB_Empty   = (sb_count == '0);
  assign misaligned = ({1'b0, offset} + size_bytes(data_write_size_2DM)) > 3'd4;

  assign MEM_Stall = !RESET && sb_full && (MemRead_2DM || MemWrite_2DM);
  assign accept    = !RESET && MemWrite_2DM && !sb_full && !misaligned;
  // The array has one port: a load owns it unless the buffer is full.
  assign drain     = !RESET && !SB_Empty && (!MemRead_2DM || sb_full);

  assign push_entry.idx  = 30'(word_idx);
  assign push_entry.data = lane_data(data_write_2DM, data_write_size_2DM, offset);
  assign push_entry.be   = byte_en(data_write_size_2DM, offset);

  store_buffer #(.SB_DEPTH(SB_DEPTH)) u_store_buffer (
    .CLK         (CLK),
    .RESET       (RESET),
    .push        (accept),
    .push_entry  (push_entry),
    .pop         (drain),
    .head_entry  (head_entry),
    .count       (sb_count),
    .lookup_idx  (30'(word_idx)),
    .lookup_base (mem[word_idx]),
    .lookup_data (fwd_data)
  );

  assign data_read_fDM = (!RESET && MemRead_2DM && !sb_full) ? fwd_data : 32'h0;

  always_ff @(posedge CLK) begin
    if (drain) begin
      for (int b = 0; b < 4; b++) begin
        if (head_entry.be[b]) mem[head_entry.idx[AW-1:0]][8*b +: 8] <= head_entry.data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) Misaligned_Err <= 1'b0;
    else       Misaligned_Err <= MemWrite_2DM && !sb_full && misaligned;
  end

  assign unused_bits = &{1'b0, data_address_2DM[31:AW+2], head_entry.idx[29:AW]};

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed scoreboard bench for data_mem_responder
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] data_address_2DM;
  logic [31:0] data_write_2DM;
  logic [1:0]  data_write_size_2DM;
  logic        MemRead_2DM;
  logic        MemWrite_2DM;
  logic [31:0] data_read_fDM;
  logic        MEM_Stall;
  logic        Misaligned_Err;
  logic        SB_Empty;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 CLK = ~CLK;

  data_mem_responder dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .data_address_2DM    (data_address_2DM),
    .data_write_2DM      (data_write_2DM),
    .data_write_size_2DM (data_write_size_2DM),
    .MemRead_2DM         (MemRead_2DM),
    .MemWrite_2DM        (MemWrite_2DM),
    .data_read_fDM       (data_read_fDM),
    .MEM_Stall           (MEM_Stall),
    .Misaligned_Err      (Misaligned_Err),
    .SB_Empty            (SB_Empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] size, input logic rst);
    @(negedge CLK);
    RESET               = rst;
    MemRead_2DM         = rd;
    MemWrite_2DM        = wr;
    data_address_2DM    = addr;
    data_write_2DM      = data;
    data_write_size_2DM = size;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
  endtask

  task automatic sw(input string tag, input logic [31:0] addr, input logic [31:0] data,
                    input logic [1:0] size);
    drive(1'b0, 1'b1, addr, data, size, 1'b0);
    chk({tag, "_stall"}, MEM_Stall, 1'b0);
  endtask

  task automatic lw(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    drive(1'b1, 1'b0, addr, 32'h0, 2'd0, 1'b0);
    chk(tag, data_read_fDM, exp_q.pop_front());
  endtask

  // Load and store together: the load sees the pre-store state.
  task automatic lsw(input string tag, input logic [31:0] addr, input logic [31:0] data,
                     input logic [31:0] exp);
    exp_q.push_back(exp);
    drive(1'b1, 1'b1, addr, data, 2'd0, 1'b0);
    chk(tag, data_read_fDM, exp_q.pop_front());
  endtask

  initial begin
    drive(1'b1, 1'b1, 32'h100, 32'h12345678, 2'd0, 1'b1);
    chk("rst_stall", MEM_Stall, 1'b0);
    chk("rst_rdata", data_read_fDM, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    idle(1);
    chk("rst_empty", SB_Empty, 1'b1);
    chk("rst_mis", Misaligned_Err, 1'b0);
    chk("idle_rdata", data_read_fDM, 32'h0);

    // Word store forwarded to the next-cycle load
    sw("sw100", 32'h100, 32'h11223344, 2'd0);
    lw("fwd100", 32'h100, 32'h11223344);
    chk("fwd100_nonempty", SB_Empty, 1'b0);
    idle(3);
    chk("drained_empty", SB_Empty, 1'b1);
    lw("arr100", 32'h100, 32'h11223344);

    // Byte store merged into the array word
    sw("sb101", 32'h101, 32'h000000AA, 2'd1);
    idle(2);
    lw("merge100", 32'h100, 32'h11AA3344);
    chk("merge100_empty", SB_Empty, 1'b1);

    // Misaligned three-byte store rejected
    sw("sw200", 32'h200, 32'h55667788, 2'd0);
    idle(2);
    sw("mis202", 32'h202, 32'h00CCDDEE, 2'd3);
    chk("mis202_pre", Misaligned_Err, 1'b0);
    idle(1);
    chk("mis202_pulse", Misaligned_Err, 1'b1);
    chk("mis202_empty", SB_Empty, 1'b1);
    idle(1);
    chk("mis202_clear", Misaligned_Err, 1'b0);
    lw("arr200", 32'h200, 32'h55667788);

    // Fill the buffer while a load holds the port, then overflow it
    for (int i = 0; i < 5; i++) sw("clr40x", 32'h400 + 32'(4*i), 32'h0, 2'd0);
    idle(3);
    for (int i = 0; i < 4; i++) lsw("fill", 32'h400 + 32'(4*i), 32'hA0000000 + 32'(i), 32'h0);
    drive(1'b1, 1'b1, 32'h410, 32'hA0000004, 2'd0, 1'b0);
    chk("full_stall", MEM_Stall, 1'b1);
    chk("full_rdata", data_read_fDM, 32'h0);
    lsw("fifth", 32'h410, 32'hA0000004, 32'h0);
    chk("fifth_stall", MEM_Stall, 1'b0);
    idle(6);
    chk("fill_empty", SB_Empty, 1'b1);
    for (int i = 0; i < 5; i++) lw("rb40x", 32'h400 + 32'(4*i), 32'hA0000000 + 32'(i));

    // Half then byte store into a cleared word
    sw("sw300", 32'h300, 32'h0, 2'd0);
    idle(2);
    sw("sh302", 32'h302, 32'h0000BEEF, 2'd2);
    sw("sb303", 32'h303, 32'h00000077, 2'd1);
    lw("fwd300", 32'h300, 32'h0000BE77);
    idle(2);
    lw("arr300", 32'h300, 32'h0000BE77);
    lsw("rw300", 32'h300, 32'hFFFFFFFF, 32'h0000BE77);
    lw("new300", 32'h300, 32'hFFFFFFFF);
    idle(2);

    // Pending stores discarded by reset
    lsw("pend400", 32'h400, 32'hDEAD0001, 32'hA0000000);
    lsw("pend404", 32'h404, 32'hDEAD0002, 32'hA0000001);
    chk("pend_nonempty", SB_Empty, 1'b0);
    drive(1'b1, 1'b1, 32'h400, 32'h0, 2'd0, 1'b1);
    chk("rst2_stall", MEM_Stall, 1'b0);
    chk("rst2_rdata", data_read_fDM, 32'h0);
    idle(1);
    chk("rst2_empty", SB_Empty, 1'b1);
    lw("old400", 32'h400, 32'hA0000000);
    lw("old404", 32'h404, 32'hA0000001);
    idle(2);
    lw("old400_late", 32'h400, 32'hA0000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
